// File: rtl/cache_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cache_port_arbiter
// Purpose  : Shares the single port of the L1 block RAM between instruction
//            fetch and data load/store. Data has priority, with an
//            anti-starvation counter for fetch, an atomic lock, and address
//            error flagging. Optional counters are enabled by ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cache_port_arbiter #(
    parameter int MEM_WORDS  = 3072,
    parameter int IDX_W      = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    // instruction fetch port
    input  logic             if_req,
    input  logic [63:0]      if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [31:0]      if_rdata,
    output logic             if_err,
    // data load/store port
    input  logic             d_req,
    input  logic             d_we,
    input  logic             d_lock,
    input  logic [63:0]      d_addr,
    input  logic [31:0]      d_wdata,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [31:0]      d_rdata,
    output logic             d_err,
    // RAM port
    output logic             mem_en,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    // status
    output logic             locked,
    output logic [31:0]      perf_if_cnt,
    output logic [31:0]      perf_d_cnt,
    output logic [31:0]      perf_stall_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [3:0]  c_STARVE_MAX = 4'(STARVE_MAX);
    localparam logic [61:0] c_MEM_WORDS  = 62'(MEM_WORDS);

    state_t     r_state_q, w_state_d;
    logic [3:0] r_starve_q, w_starve_d;
    logic       r_rd_pend_q, w_rd_pend_d;   // a read response is due this cycle
    logic       r_owner_q, w_owner_d;       // 1 = response belongs to data port
    logic       r_err_q, w_err_d;           // pending response is an error

    logic       w_if_bad, w_d_bad;
    logic       w_if_gnt, w_d_gnt;
    logic       w_rsp_if, w_rsp_d;
    logic [31:0] w_rsp_data;

    // Address checks: misaligned or beyond the RAM depth
    always_comb begin
        w_if_bad = (if_addr[1:0] != 2'b00) || (if_addr[63:2] >= c_MEM_WORDS);
        w_d_bad  = (d_addr[1:0]  != 2'b00) || (d_addr[63:2]  >= c_MEM_WORDS);
    end

    // Arbitration: data first, fetch wins when starved, fetch blocked when locked
    always_comb begin
        w_if_gnt = 1'b0;
        w_d_gnt  = 1'b0;
        if (!reset) begin
            w_if_gnt = (r_state_q == ST_IDLE) && if_req &&
                       (!d_req || (r_starve_q == c_STARVE_MAX));
            w_d_gnt  = d_req && !w_if_gnt;
        end
    end

    // RAM request drive; erroring accesses are granted but never reach RAM
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_if_gnt) begin
            mem_en   = !w_if_bad;
            mem_addr = if_addr[IDX_W+1:2];
        end else if (w_d_gnt) begin
            mem_en    = !w_d_bad;
            mem_we    = d_we && !w_d_bad;
            mem_addr  = d_addr[IDX_W+1:2];
            mem_wdata = d_wdata;
        end
    end

    // Next lock state and starvation count
    always_comb begin
        w_state_d  = r_state_q;
        w_starve_d = r_starve_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_d_gnt && !d_we && d_lock && !w_d_bad)
                    w_state_d = ST_LOCKED;
                if (w_if_gnt)
                    w_starve_d = 4'd0;
                else if (if_req && (r_starve_q < c_STARVE_MAX))
                    w_starve_d = r_starve_q + 4'd1;
            end
            ST_LOCKED: begin
                if (w_d_gnt && (w_d_bad || (d_we && !d_lock)))
                    w_state_d = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // Response tag for the read issued this cycle
    always_comb begin
        w_rd_pend_d = w_if_gnt || (w_d_gnt && !d_we);
        w_owner_d   = w_d_gnt;
        w_err_d     = w_if_gnt ? w_if_bad : w_d_bad;
    end

    // Lock state machine and starvation counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= ST_IDLE;
            r_starve_q <= 4'd0;
        end else begin
            r_state_q  <= w_state_d;
            r_starve_q <= w_starve_d;
        end
    end

    // Owner tag register; reset drops any in-flight response
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_pend_q <= 1'b0;
            r_owner_q   <= 1'b0;
            r_err_q     <= 1'b0;
        end else begin
            r_rd_pend_q <= w_rd_pend_d;
            r_owner_q   <= w_owner_d;
            r_err_q     <= w_err_d;
        end
    end

    // Route the response; errors return zero data
    always_comb begin
        w_rsp_if   = !reset && r_rd_pend_q && !r_owner_q;
        w_rsp_d    = !reset && r_rd_pend_q &&  r_owner_q;
        w_rsp_data = r_err_q ? 32'd0 : mem_rdata;
    end

    assign if_gnt    = w_if_gnt;
    assign if_rvalid = w_rsp_if;
    assign if_rdata  = w_rsp_if ? w_rsp_data : 32'd0;
    assign if_err    = w_rsp_if && r_err_q;

    assign d_gnt     = w_d_gnt;
    assign d_rvalid  = w_rsp_d;
    assign d_rdata   = w_rsp_d ? w_rsp_data : 32'd0;
    assign d_err     = (w_d_gnt && d_we && w_d_bad) || (w_rsp_d && r_err_q);

    assign locked    = !reset && (r_state_q == ST_LOCKED);

`ifdef ARB_PERF_EN
    logic [31:0] r_perf_if_q, r_perf_d_q, r_perf_stall_q;
    logic        w_stall;

    assign w_stall = (if_req && !w_if_gnt) || (d_req && !w_d_gnt);

    // Saturating grant and stall counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_if_q    <= 32'd0;
            r_perf_d_q     <= 32'd0;
            r_perf_stall_q <= 32'd0;
        end else begin
            if (w_if_gnt && (r_perf_if_q != 32'hFFFF_FFFF))
                r_perf_if_q <= r_perf_if_q + 32'd1;
            if (w_d_gnt && (r_perf_d_q != 32'hFFFF_FFFF))
                r_perf_d_q <= r_perf_d_q + 32'd1;
            if (w_stall && (r_perf_stall_q != 32'hFFFF_FFFF))
                r_perf_stall_q <= r_perf_stall_q + 32'd1;
        end
    end

    assign perf_if_cnt    = reset ? 32'd0 : r_perf_if_q;
    assign perf_d_cnt     = reset ? 32'd0 : r_perf_d_q;
    assign perf_stall_cnt = reset ? 32'd0 : r_perf_stall_q;
`else
    assign perf_if_cnt    = 32'd0;
    assign perf_d_cnt     = 32'd0;
    assign perf_stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cache_port_arbiter
// Purpose  : Directed self-checking bench for cache_port_arbiter with a
//            behavioural synchronous-read RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_gnt, if_rvalid, if_err;
    logic [63:0] if_addr;
    logic [31:0] if_rdata;
    logic        d_req, d_we, d_lock, d_gnt, d_rvalid, d_err;
    logic [63:0] d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        locked;
    logic [31:0] perf_if_cnt, perf_d_cnt, perf_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ram [0:4095];

    always #5 clk = ~clk;

    cache_port_arbiter #(
        .MEM_WORDS (3072),
        .IDX_W     (12),
        .STARVE_MAX(4)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_gnt        (if_gnt),
        .if_rvalid     (if_rvalid),
        .if_rdata      (if_rdata),
        .if_err        (if_err),
        .d_req         (d_req),
        .d_we          (d_we),
        .d_lock        (d_lock),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_gnt         (d_gnt),
        .d_rvalid      (d_rvalid),
        .d_rdata       (d_rdata),
        .d_err         (d_err),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .locked        (locked),
        .perf_if_cnt   (perf_if_cnt),
        .perf_d_cnt    (perf_d_cnt),
        .perf_stall_cnt(perf_stall_cnt)
    );

    // Synchronous-read RAM: read data appears one cycle after mem_en
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1ns later
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req  = 1'b0; if_addr = 64'd0;
        d_req   = 1'b0; d_we    = 1'b0; d_lock = 1'b0;
        d_addr  = 64'd0; d_wdata = 32'd0;
    endtask

    logic [5:0]  gnt_pattern;
    logic [31:0] perf_exp;

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 32'hA500_0000 | 32'(i);
        mem_rdata = 32'd0;
        idle_inputs();
        reset = 1'b1;

        // Outputs stay zero in reset even with both requests asserted
        step(); if_req = 1'b1; d_req = 1'b1; if_addr = 64'h10; d_addr = 64'h20;
        step(); #1;
        chk("rst_gnts", {62'd0, if_gnt, d_gnt}, 64'd0);
        chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
        chk("rst_rsp", {if_rvalid, d_rvalid, if_err, d_err, locked}, 64'd0);
        chk("rst_rdata", {if_rdata, d_rdata}, 64'd0);
        chk("rst_perf", {32'd0, perf_if_cnt | perf_d_cnt | perf_stall_cnt}, 64'd0);
        step(); idle_inputs(); reset = 1'b0;

        // Fetch only
        step(); if_req = 1'b1; if_addr = 64'h10; #1;
        chk("fetch_gnt", {61'd0, if_gnt, d_gnt, mem_we}, 64'b100);
        chk("fetch_mem", {51'd0, mem_en, mem_addr}, {51'd0, 1'b1, 12'd4});
        step(); idle_inputs(); #1;
        chk("fetch_rsp", {if_rvalid, if_err, if_rdata}, {1'b1, 1'b0, 32'hA500_0004});

        // Write then read the same word
        step(); d_req = 1'b1; d_we = 1'b1; d_addr = 64'h2004; d_wdata = 32'hDEAD_BEEF; #1;
        chk("wr_gnt", {d_gnt, mem_en, mem_we, d_err}, 4'b1110);
        chk("wr_mem", {mem_addr, mem_wdata}, {12'h801, 32'hDEAD_BEEF});
        step(); d_we = 1'b0; #1;
        chk("rd_gnt", {d_gnt, mem_en, mem_we}, 3'b110);
        step(); idle_inputs(); #1;
        chk("rd_rsp", {d_rvalid, d_err, d_rdata}, {1'b1, 1'b0, 32'hDEAD_BEEF});

        // Both requesting continuously: D D D D F D
        gnt_pattern = 6'b010000;  // bit i = 1 means fetch wins cycle i
        step(); if_req = 1'b1; if_addr = 64'h20; d_req = 1'b1; d_addr = 64'h0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("starve_c%0d", i), {62'd0, if_gnt, d_gnt},
                {62'd0, gnt_pattern[i], ~gnt_pattern[i]});
            if (i < 5) step();
        end
        step(); idle_inputs();

        // Misaligned read
        step(); d_req = 1'b1; d_addr = 64'h2002; #1;
        chk("mis_gnt", {d_gnt, mem_en, d_err}, 3'b100);
        step(); idle_inputs(); #1;
        chk("mis_rsp", {d_rvalid, d_err, d_rdata}, {1'b1, 1'b1, 32'd0});

        // Out-of-range write
        step(); d_req = 1'b1; d_we = 1'b1; d_addr = 64'h3000; d_wdata = 32'h1234_5678; #1;
        chk("oor_gnt", {d_gnt, d_err, mem_en, mem_we}, 4'b1100);
        step(); idle_inputs(); #1;
        chk("oor_noerr", {d_err, d_rvalid}, 2'b00);
        chk("oor_ram", {32'd0, ram[12'hC00]}, {32'd0, 32'hA500_0C00});

        // Locked read, fetch held off, unlock by write
        step(); d_req = 1'b1; d_lock = 1'b1; d_addr = 64'h2008; #1;
        chk("lk_gnt", {d_gnt, locked}, 2'b10);
        step(); idle_inputs(); if_req = 1'b1; if_addr = 64'h30; #1;
        chk("lk_state", {locked, d_rvalid, if_gnt}, 3'b110);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin step(); #1; end
            chk($sformatf("lk_block%0d", i), {63'd0, if_gnt}, 64'd0);
        end
        step(); d_req = 1'b1; d_we = 1'b1; d_lock = 1'b0; d_addr = 64'h2008;
        d_wdata = 32'h0BAD_F00D; #1;
        chk("unlk_gnt", {d_gnt, if_gnt, locked}, 3'b101);
        step(); d_req = 1'b0; d_we = 1'b0; #1;
        chk("unlk_state", {locked, if_gnt}, 2'b01);
        step(); idle_inputs(); #1;
        chk("unlk_fetch", {if_rvalid, if_rdata}, {1'b1, 32'hA500_000C});

        // Reset right after a locked read grant drops the response
        step(); d_req = 1'b1; d_lock = 1'b1; d_addr = 64'h2008; #1;
        chk("rr_gnt", {63'd0, d_gnt}, 64'd1);
        step(); idle_inputs(); reset = 1'b1; #1;
        chk("rr_rsp", {d_rvalid, if_rvalid, locked, d_err}, 4'b0000);
        chk("rr_mem", {mem_en, d_rdata}, 33'd0);
        step(); reset = 1'b0; #1;
        chk("rr_after", {d_rvalid, locked}, 2'b00);
        chk("rr_perf0", {perf_if_cnt, perf_d_cnt}, 64'd0);

        // Three fetch grants for the counters
        for (int i = 0; i < 3; i++) begin
            step(); if_req = 1'b1; if_addr = 64'(4 * i);
        end
        step(); idle_inputs(); #1;
`ifdef ARB_PERF_EN
        perf_exp = 32'd3;
`else
        perf_exp = 32'd0;
`endif
        chk("perf_if", {32'd0, perf_if_cnt}, {32'd0, perf_exp});
        chk("perf_d_stall", {perf_d_cnt, perf_stall_cnt}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
